// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage.
//   MAX_LOG2N  : widest index the bit-reversal helper handles
//   rd_state_t : read-side FSM states
//   log2n()    : index width for an N-point frame
//   bitrev()   : reverse the low 'bits' bits of an index
package fft_pkg;

    localparam int MAX_LOG2N = 16;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    function automatic int log2n(input int n);
        return $clog2(n);
    endfunction

    // Reverse all MAX_LOG2N bits, then shift the reversed field down so
    // only the low 'bits' bits of the input end up reversed in place.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                    input int bits);
        logic [MAX_LOG2N-1:0] full;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            full[i] = value[MAX_LOG2N-1-i];
        end
        return full >> (MAX_LOG2N - bits);
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample bus between the FFT core, the reorder stage and its consumer.
//   enable_in / in_re / in_im            : bit-reversed samples from the core
//   enable_out / out_re / out_im / out_index : natural-order samples out
// Modports: master = side driving the input samples (core / bench),
//           slave  = the reorder stage.
interface fft_bitrev_reorder_if #(
    parameter int N     = 32,
    parameter int WIDTH = 8
);
    localparam int LOG2N = fft_pkg::log2n(N);

    logic                    enable_in;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    enable_out;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [LOG2N-1:0]        out_index;

    modport master (
        output enable_in, in_re, in_im,
        input  enable_out, out_re, out_im, out_index
    );

    modport slave (
        input  enable_in, in_re, in_im,
        output enable_out, out_re, out_im, out_index
    );
endinterface

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port.
//   clk     : clock
//   wr_en   : write strobe, wr_addr / wr_data : write address and word
//   rd_en   : read strobe,  rd_addr          : read address
//   rd_data : word registered on the edge where rd_en is high
// Address is {bank, index}; contents are never cleared.
module fft_reorder_ram #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order.
// Each frame is written into one bank of a ping-pong buffer at the
// bit-reversed address of its arrival count; once a bank is full it is read
// out linearly over N contiguous cycles while the other bank fills.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of fft_bitrev_reorder_if (samples in, natural-order
//              samples plus bin index out)
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = 32,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    fft_bitrev_reorder_if.slave bus
);
    localparam int LOG2N = log2n(N);
    localparam int AW    = LOG2N + 1;
    localparam int DW    = 2 * WIDTH;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    // Write side
    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic [LOG2N-1:0] wr_idx;
    logic             accept;
    logic             launch;

    // A sample offered on a reset edge is dropped.
    assign accept = bus.enable_in && !rst;
    assign launch = accept && (wr_cnt == LAST);
    assign wr_idx = LOG2N'(bitrev(MAX_LOG2N'(wr_cnt), LOG2N));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (launch) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read side FSM
    rd_state_t        state, state_nxt;
    logic [LOG2N-1:0] rd_cnt, rd_cnt_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic             pend, pend_nxt;
    logic             pend_bank, pend_bank_nxt;
    logic             rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RD_IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_cnt    <= rd_cnt_nxt;
            rd_bank   <= rd_bank_nxt;
            pend      <= pend_nxt;
            pend_bank <= pend_bank_nxt;
        end
    end

    // On a launch the read bank is the current write bank, i.e. the bank
    // being completed on this very edge.
    always_comb begin
        state_nxt     = state;
        rd_cnt_nxt    = rd_cnt;
        rd_bank_nxt   = rd_bank;
        pend_nxt      = pend;
        pend_bank_nxt = pend_bank;
        unique case (state)
            RD_IDLE: begin
                if (launch) begin
                    state_nxt   = RD_READ;
                    rd_cnt_nxt  = '0;
                    rd_bank_nxt = wr_bank;
                end
            end
            RD_READ: begin
                if (rd_cnt == LAST) begin
                    if (pend) begin
                        rd_cnt_nxt    = '0;
                        rd_bank_nxt   = pend_bank;
                        pend_nxt      = launch;
                        pend_bank_nxt = wr_bank;
                    end else if (launch) begin
                        rd_cnt_nxt  = '0;
                        rd_bank_nxt = wr_bank;
                    end else begin
                        state_nxt = RD_IDLE;
                    end
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                    if (launch) begin
                        pend_nxt      = 1'b1;
                        pend_bank_nxt = wr_bank;
                    end
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // The RAM is addressed from the next-state counters so the word for
    // rd_cnt is already registered while the FSM sits on rd_cnt; that keeps
    // the in-to-out latency at one cycle after the frame-completing edge.
    assign rd_en = (state_nxt == RD_READ);

    logic [DW-1:0] rd_data_p0;

    fft_reorder_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data ({bus.in_re, bus.in_im}),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank_nxt, rd_cnt_nxt}),
        .rd_data (rd_data_p0)
    );

    // ---- p0 -> p1: output registers ----
    logic                    vld_p0;
    logic                    vld_p1;
    logic signed [WIDTH-1:0] re_p1;
    logic signed [WIDTH-1:0] im_p1;
    logic [LOG2N-1:0]        idx_p1;

    assign vld_p0 = (state == RD_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            re_p1  <= '0;
            im_p1  <= '0;
            idx_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                re_p1  <= rd_data_p0[DW-1:WIDTH];
                im_p1  <= rd_data_p0[WIDTH-1:0];
                idx_p1 <= rd_cnt;
            end
        end
    end

    assign bus.enable_out = vld_p1;
    assign bus.out_re     = re_p1;
    assign bus.out_im     = im_p1;
    assign bus.out_index  = idx_p1;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
    localparam int NA = 32;
    localparam int WA = 8;
    localparam int NB = 4;
    localparam int WB = 16;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   edge_no = 0;
    int   checks  = 0;
    int   errors  = 0;

    fft_bitrev_reorder_if #(.N(NA), .WIDTH(WA)) bus_a();
    fft_bitrev_reorder_if #(.N(NB), .WIDTH(WB)) bus_b();

    fft_bitrev_reorder #(.N(NA), .WIDTH(WA)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    fft_bitrev_reorder #(.N(NB), .WIDTH(WB)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Everything enable_out presents on DUT A, tagged with the edge number
    // after which it became visible.
    typedef struct {
        int re;
        int im;
        int idx;
        int edge_n;
    } obs_t;
    obs_t obs_q[$];

    always @(negedge clk) begin
        if (bus_a.enable_out === 1'b1) begin
            obs_q.push_back('{int'(bus_a.out_re), int'(bus_a.out_im),
                              int'(bus_a.out_index), edge_no});
        end
    end

    typedef struct {
        string name;
        int    nframes;
        int    gap_every;
        int    exp_lat;   // first accepted edge -> edge after which bin 0 shows
        int    exp_cnt;   // samples with enable_out high
    } scen_t;

    typedef struct {
        int in_re;
        int in_im;
        int exp_re;
        int exp_im;
    } vec_b_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tb_bitrev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    function automatic int s8(input int v);
        logic signed [7:0] t;
        t = v[7:0];
        return int'(t);
    endfunction

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_a.enable_in = 1'b0;
        end
    endtask

    task automatic send_a(input int re, input int im, output int acc);
        @(negedge clk);
        bus_a.enable_in = 1'b1;
        bus_a.in_re     = 8'(re);
        bus_a.in_im     = 8'(im);
        acc             = edge_no + 1;
    endtask

    // Frame f, arrival k carries in_re = bitrev5(k) + 32f, in_im = -bitrev5(k).
    task automatic play_frames(input int nframes, input int gap_every, output int first_acc);
        int acc;
        int idx;
        first_acc = 0;
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < NA; k++) begin
                idx = tb_bitrev(k, 5);
                send_a(idx + 32 * f, -idx, acc);
                if (f == 0 && k == 0) first_acc = acc;
                if (gap_every > 0 && (k % gap_every) == gap_every - 1) idle_a(1);
            end
        end
        idle_a(1);
    endtask

    task automatic check_queue(input string tag, input int exp_cnt, input int exp_first);
        int n;
        int f;
        int k;
        check($sformatf("%s count", tag), obs_q.size(), exp_cnt);
        n = (obs_q.size() < exp_cnt) ? obs_q.size() : exp_cnt;
        for (int i = 0; i < n; i++) begin
            f = i / NA;
            k = i % NA;
            check($sformatf("%s re[%0d]", tag, i),   obs_q[i].re,     s8(k + 32 * f));
            check($sformatf("%s im[%0d]", tag, i),   obs_q[i].im,     s8(-k));
            check($sformatf("%s idx[%0d]", tag, i),  obs_q[i].idx,    k);
            check($sformatf("%s edge[%0d]", tag, i), obs_q[i].edge_n, exp_first + i);
        end
    endtask

    initial begin
        scen_t  scen[3];
        vec_b_t vb[4];
        int     first_acc;
        int     acc;
        int     found;

        scen[0] = '{"single",   1, 0, 32, 32};
        scen[1] = '{"b2b3",     3, 0, 32, 96};
        // 10 one-cycle gaps (after arrivals 2,5,...,29): last sample at +41.
        scen[2] = '{"gapped",   1, 3, 42, 32};

        // Arrival order carries natural bins 0,2,1,3.
        vb[0] = '{-32768,  32767, -32768,  32767};
        vb[1] = '{     1,     -1,  32767, -32768};
        vb[2] = '{ 32767, -32768,      1,     -1};
        vb[3] = '{    -1,      0,     -1,      0};

        bus_a.enable_in = 1'b0;
        bus_a.in_re     = '0;
        bus_a.in_im     = '0;
        bus_b.enable_in = 1'b0;
        bus_b.in_re     = '0;
        bus_b.in_im     = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);

        check("reset enable_out", int'(bus_a.enable_out), 0);
        check("reset out_re",     int'(bus_a.out_re),     0);
        check("reset out_im",     int'(bus_a.out_im),     0);
        check("reset out_index",  int'(bus_a.out_index),  0);
        check("reset b enable",   int'(bus_b.enable_out), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int s = 0; s < 3; s++) begin
            obs_q.delete();
            play_frames(scen[s].nframes, scen[s].gap_every, first_acc);
            idle_a(2 * NA + 8);
            check_queue(scen[s].name, scen[s].exp_cnt, first_acc + scen[s].exp_lat);
        end

        // Partial frame cut by reset, then a clean frame.
        obs_q.delete();
        for (int k = 0; k < 20; k++) send_a(100 + k, 5, acc);
        @(negedge clk);
        rst_a           = 1'b1;
        bus_a.enable_in = 1'b1;
        bus_a.in_re     = 8'(77);
        @(negedge clk);
        rst_a           = 1'b0;
        bus_a.enable_in = 1'b0;
        play_frames(1, 0, first_acc);
        idle_a(2 * NA + 8);
        check_queue("rst_partial", NA, first_acc + NA);

        // Reset in the middle of a readout.
        obs_q.delete();
        play_frames(1, 0, first_acc);
        found = 0;
        for (int c = 0; c < 80 && found == 0; c++) begin
            @(negedge clk);
            if (bus_a.enable_out === 1'b1 && bus_a.out_index == 5'd10) found = 1;
        end
        check("rst_read reached idx10", found, 1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("rst_read enable_out", int'(bus_a.enable_out), 0);
        check("rst_read out_re",     int'(bus_a.out_re),     0);
        check("rst_read out_im",     int'(bus_a.out_im),     0);
        check("rst_read out_index",  int'(bus_a.out_index),  0);
        idle_a(40);
        check("rst_read no resume", obs_q.size(), 11);
        obs_q.delete();
        play_frames(1, 0, first_acc);
        idle_a(2 * NA + 8);
        check_queue("after_rst", NA, first_acc + NA);

        // N=4, WIDTH=16 bit-exact extremes.
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            bus_b.enable_in = 1'b1;
            bus_b.in_re     = 16'(vb[k].in_re);
            bus_b.in_im     = 16'(vb[k].in_im);
        end
        @(negedge clk);
        bus_b.enable_in = 1'b0;
        check("b latency enable", int'(bus_b.enable_out), 0);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            check($sformatf("b enable[%0d]", k), int'(bus_b.enable_out), 1);
            check($sformatf("b re[%0d]", k),     int'(bus_b.out_re),     vb[k].exp_re);
            check($sformatf("b im[%0d]", k),     int'(bus_b.out_im),     vb[k].exp_im);
            check($sformatf("b idx[%0d]", k),    int'(bus_b.out_index),  k);
        end
        @(negedge clk);
        check("b enable falls", int'(bus_b.enable_out), 0);
        check("b hold re",      int'(bus_b.out_re),     -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
